ram_port_arbiter: RTL
=====================

# ram_port_arbiter

- Shares one 16x4 single-write-port RAM between two requesters, A and B.
- Each requester issues read or write requests with a req/gnt handshake.
- A round-robin arbiter accepts at most one access per cycle.
- Read data returns registered, one cycle after the grant.
- Sits between the RAM storage and client logic (e.g. a config loader and a datapath reader) so neither client drives the memory ports directly.

## Interface
- `DW`, 4, data width.
- `AW`, 4, address width.
- `DEPTH`, 16, words; fixed at `1<<AW`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_a`, `req_b`  in  1  access request; held until granted.
- `we_a`, `we_b`  in  1  1 = write, 0 = read; qualified by req.
- `addr_a`, `addr_b`  in  AW  word address.
- `wdata_a`, `wdata_b`  in  DW  write data.
- `gnt_a`, `gnt_b`  out  1  combinational accept; transfer occurs when `req & gnt` at a rising edge.
- `rvalid_a`, `rvalid_b`  out  1  one-cycle pulse, read data valid.
- `rdata_a`, `rdata_b`  out  DW  read data; holds last value between reads.
- `init_done`  out  1  1 = arbiter accepting requests.

## Operation
- **States.**
  - INIT: present only with the configuration macro; see Configuration.
  - RUN: normal arbitration.
- **Grant rule.**
  - Grants are issued only in RUN.
  - At most one of `gnt_a`/`gnt_b` is high in any cycle.
  - Only A requesting: grant A. Only B requesting: grant B. Same rule every cycle, back-to-back.
  - Both requesting: grant the side indicated by the priority pointer `prio`.
  - After any grant, `prio` points to the other side.
  - `prio` reset value = A.
- **Handshake.**
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - Requester may drop req or change fields in the cycle after gnt.
  - Deasserting req before gnt withdraws the request; no side effect.
- **Write.** `mem[addr] <= wdata` at the granting edge.
- **Read.**
  - At the granting edge, `rdata_x <= mem[addr]` and `rvalid_x <= 1`.
  - `rvalid_x` clears on the next edge unless another read is granted to that side.
- **Read-after-write.** A read granted the cycle after a write to the same address returns the new data. Write-then-read ordering is strict by grant order.
- **Addressing.** Full AW-bit address; no wrap or truncation, since `DEPTH = 2^AW`.
- **Memory contents.** Not reset by `rst_n`, except via the INIT clear.

## Timing
- **Reset values:**
  - `gnt_a`/`gnt_b` = 0.
  - `rvalid_a`/`rvalid_b` = 0.
  - `rdata_a`/`rdata_b` = 0.
  - `init_done` = 0.
  - `prio` = A.
  - Clear counter = 0.
- **Read latency:** grant edge → `rvalid`/`rdata` visible 1 cycle later.
- **Write latency:** visible to reads granted from the next cycle on.
- **Throughput:** one access per cycle, aggregate.
- **Fairness:** with both requesters continuously active, grants alternate A, B, A, B.
- **Reset asserted mid-operation:**
  - All outputs return to their reset values immediately; `rvalid` and `rdata` are cleared asynchronously.
  - An in-flight read is dropped.
  - A write granted at an edge coincident with reset assertion is not guaranteed.
- **After reset release:** without the macro, `init_done` = 1 from the first rising edge.

## Configuration
- Macro: `RAM_ARB_INIT_CLEAR_EN`.
- **Defined:**
  - After reset release, FSM enters INIT.
  - Writes 0 to addresses 0..DEPTH-1, one per cycle, via an internal counter.
  - `gnt_*` held 0 during the sweep.
  - `init_done` rises on the edge after address DEPTH-1 is written (DEPTH cycles after release).
  - FSM then enters RUN.
  - Reset during INIT restarts the sweep at address 0.
- **Undefined:**
  - No INIT state; FSM is RUN from reset.
  - Memory power-up contents undefined.

## Structure
- Shared package `ram_arb_pkg`: `DW`/`AW`/`DEPTH` defaults, requester enum (`ARB_A`, `ARB_B`), FSM state enum (`ST_INIT`, `ST_RUN`).
- Sub-module `ram_arb_mem`: DEPTH x DW storage, synchronous write (`we`, `waddr`, `wdata`), combinational read (`raddr` → `rdata`).
- Arbiter, FSM, clear counter and output registers live in the top.

## Test plan
- **Reset state:** assert `rst_n` = 0 → all gnt/rvalid/rdata = 0, `init_done` = 0. Release → `init_done` = 1 at first edge (macro off) or after 16 cycles (macro on).
- **Single-side write/read:** A writes `addr` 5 = 4'hA (granted same cycle), then reads 5 → `rvalid_a` = 1 with `rdata_a` = 4'hA one cycle after grant.
- **Contention:** A and B request continuously for 6 cycles → grants A, B, A, B, A, B. A writes 3 = 4'h7, B reads 3 next → `rdata_b` = 4'h7.
- **Withdrawal and stability:** B raises req, drops it before grant while A holds priority → no `rvalid_b`, memory unchanged. Held req with changing fields is a bench error, flagged by assertion.
- **Init clear (macro on):** preload via a run, reset, wait for `init_done` → reads of addresses 0..15 all return 4'h0. Reset at sweep count 8 → sweep restarts, `init_done` 16 cycles after the new release.
- **Mid-operation reset:** reset in the cycle after a read grant → `rvalid` forced 0, `prio` = A, so the next contended grant goes to A.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Widths, requester and FSM state encodings.
package ram_arb_pkg;

  localparam int ARB_DW = 4;
  localparam int ARB_AW = 4;
  localparam int ARB_DEPTH = 1 << ARB_AW;

  typedef enum logic {
    ARB_A = 1'b0,
    ARB_B = 1'b1
  } arb_side_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ram_arb_mem.sv
// DEPTH x DW storage: synchronous write, combinational read.
// Ports: clk, we/waddr/wdata write port, raddr -> rdata.
module ram_arb_mem
  import ram_arb_pkg::*;
#(
  parameter int DW    = ARB_DW,
  parameter int AW    = ARB_AW,
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM between requesters A and B.
// Ports: clk, rst_n, per-side req/we/addr/wdata in, gnt/rvalid/rdata
// out, init_done. RAM_ARB_INIT_CLEAR_EN adds a zeroing sweep.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW = ARB_DW,
  parameter int AW = ARB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          init_done
);

  localparam int DEPTH = 1 << AW;

`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam arb_state_e RST_ST = ST_INIT;
  logic [AW-1:0] clr_cnt;
`else
  localparam arb_state_e RST_ST = ST_RUN;
`endif

  arb_state_e state;
  arb_side_e  prio;
  logic       accept;
  logic       rd_a;
  logic       rd_b;

  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [AW-1:0] m_raddr;
  logic [DW-1:0] m_rdata;

  assign accept = (state == ST_RUN) && init_done;

  // Contention goes to prio; a lone requester always wins.
  assign gnt_a = accept && req_a &&
                 (!req_b || prio == ARB_A);
  assign gnt_b = accept && req_b &&
                 (!req_a || prio == ARB_B);

  assign rd_a = gnt_a && !we_a;
  assign rd_b = gnt_b && !we_b;

  assign m_raddr = gnt_b ? addr_b : addr_a;

  always_comb begin
    m_we    = 1'b0;
    m_waddr = addr_a;
    m_wdata = wdata_a;
    unique case (1'b1)
`ifdef RAM_ARB_INIT_CLEAR_EN
      (state == ST_INIT): begin
        m_we    = 1'b1;
        m_waddr = clr_cnt;
        m_wdata = '0;
      end
`endif
      gnt_b: begin
        m_we    = we_b;
        m_waddr = addr_b;
        m_wdata = wdata_b;
      end
      default: begin
        m_we    = gnt_a && we_a;
      end
    endcase
  end

  ram_arb_mem #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (m_we),
    .waddr (m_waddr),
    .wdata (m_wdata),
    .raddr (m_raddr),
    .rdata (m_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_ST;
      init_done <= 1'b0;
      prio      <= ARB_A;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
`ifdef RAM_ARB_INIT_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      rvalid_a <= rd_a;
      rvalid_b <= rd_b;
      if (rd_a) rdata_a <= m_rdata;
      if (rd_b) rdata_b <= m_rdata;
      if (gnt_a) prio <= ARB_B;
      else if (gnt_b) prio <= ARB_A;
`ifdef RAM_ARB_INIT_CLEAR_EN
      unique case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: init_done <= 1'b1;
        default: state <= ST_INIT;
      endcase
`else
      state     <= ST_RUN;
      init_done <= 1'b1;
`endif
    end
  end

endmodule
